// File: rtl/ex_branch_unit.sv
// ex_branch_unit
//   Execute-stage ALU and next-PC resolution for the pipelined RV32I core.
//   Selects the ALU B operand, computes the ALU result and compare flags,
//   registers result/flags/branch target/PC-select code, and from those
//   registered values produces the next fetch address and a redirect strobe
//   that flushes IF/ID and ID/EX.
//
//   Optional feature macro: EX_SHIFT_EN
//     defined   : ops 15/16/17 perform sll/srl/sra by B[4:0]
//     undefined : ops 15/16/17 return 0, no shifter is built
//
// Ports
//   clk         in   CPU clock, rising edge
//   rst         in   asynchronous reset, active-high
//   pc_i        in   PC of the instruction in EX
//   rd1_i       in   register operand A
//   rd2_i       in   register operand B
//   imm_i       in   sign-extended immediate
//   alu_src_i   in   0: B = rd2_i, 1: B = imm_i
//   alu_op_i    in   ALU operation code (5 bits)
//   pc_src_i    in   PC-select code of the instruction in EX (3 bits)
//   pc_plus4_i  in   sequential fetch address from IF
//   alu_c_o     out  combinational ALU result
//   zero_o      out  combinational alu_c_o == 0
//   less_o      out  combinational A < B (unsigned for ops 8, 9, 11)
//   result_q_o  out  registered ALU result
//   next_pc_o   out  next fetch address
//   redirect_o  out  taken branch/jump, pipeline flush request

module ex_branch_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] rd1_i,
    input  logic [DATA_W-1:0] rd2_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic              alu_src_i,
    input  logic [4:0]        alu_op_i,
    input  logic [2:0]        pc_src_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    output logic [DATA_W-1:0] alu_c_o,
    output logic              zero_o,
    output logic              less_o,
    output logic [DATA_W-1:0] result_q_o,
    output logic [DATA_W-1:0] next_pc_o,
    output logic              redirect_o
);

    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_diff;
    logic              w_lt_s;
    logic              w_lt_u;
    logic [DATA_W-1:0] w_alu;
    logic              w_taken;
    logic              w_redirect;
    logic [DATA_W-1:0] w_next_pc;

    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_less;
    logic [DATA_W-1:0] r_target;
    logic [2:0]        r_pc_src;

    assign w_b    = alu_src_i ? imm_i : rd2_i;
    assign w_diff = rd1_i - w_b;
    assign w_lt_s = $signed(rd1_i) < $signed(w_b);
    assign w_lt_u = rd1_i < w_b;

    always_comb begin
        w_alu = '0;
        case (alu_op_i)
            5'd1:                            w_alu = w_b;
            5'd2:                            w_alu = pc_i + w_b;
            5'd3:                            w_alu = rd1_i + w_b;
            5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9: w_alu = w_diff;
            5'd10:                           w_alu = {{(DATA_W-1){1'b0}}, w_lt_s};
            5'd11:                           w_alu = {{(DATA_W-1){1'b0}}, w_lt_u};
            5'd12:                           w_alu = rd1_i ^ w_b;
            5'd13:                           w_alu = rd1_i | w_b;
            5'd14:                           w_alu = rd1_i & w_b;
`ifdef EX_SHIFT_EN
            5'd15:                           w_alu = rd1_i << w_b[4:0];
            5'd16:                           w_alu = rd1_i >> w_b[4:0];
            5'd17:                           w_alu = $unsigned($signed(rd1_i) >>> w_b[4:0]);
`endif
            default:                         w_alu = '0;
        endcase
    end

    assign alu_c_o = w_alu;
    assign zero_o  = (w_alu == '0);
    // Only the unsigned branch/set ops use the unsigned comparator.
    assign less_o  = ((alu_op_i == 5'd8) || (alu_op_i == 5'd9) || (alu_op_i == 5'd11))
                     ? w_lt_u : w_lt_s;

    always_comb begin
        w_taken   = 1'b0;
        w_next_pc = pc_plus4_i;
        case (r_pc_src)
            3'd1: w_taken = r_zero;
            3'd2: w_taken = !r_zero;
            3'd3: w_taken = r_less;
            3'd4: w_taken = !r_less;
            3'd5: w_taken = 1'b1;
            3'd6: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
        if (w_taken) begin
            if (r_pc_src == 3'd6) begin
                w_next_pc = {r_result[DATA_W-1:1], 1'b0};
            end else begin
                w_next_pc = r_target;
            end
        end
    end

    assign w_redirect = w_taken;
    assign next_pc_o  = w_next_pc;
    assign redirect_o = w_redirect;
    assign result_q_o = r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_less   <= 1'b0;
            r_target <= '0;
            r_pc_src <= 3'd0;
        end else begin
            r_result <= w_alu;
            r_zero   <= zero_o;
            r_less   <= less_o;
            r_target <= pc_i + imm_i;
            // The instruction behind a redirect is on the wrong path; strip its
            // PC-select so it can never redirect itself.
            r_pc_src <= w_redirect ? 3'd0 : pc_src_i;
        end
    end

endmodule

// File: tb/tb_ex_branch_unit.sv
module tb_ex_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i, rd1_i, rd2_i, imm_i, pc_plus4_i;
    logic        alu_src_i;
    logic [4:0]  alu_op_i;
    logic [2:0]  pc_src_i;
    logic [31:0] alu_c_o, result_q_o, next_pc_o;
    logic        zero_o, less_o, redirect_o;

    ex_branch_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .rd1_i(rd1_i), .rd2_i(rd2_i),
        .imm_i(imm_i), .alu_src_i(alu_src_i), .alu_op_i(alu_op_i),
        .pc_src_i(pc_src_i), .pc_plus4_i(pc_plus4_i), .alu_c_o(alu_c_o),
        .zero_o(zero_o), .less_o(less_o), .result_q_o(result_q_o),
        .next_pc_o(next_pc_o), .redirect_o(redirect_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] c;
        logic        z;
        logic        l;
        logic [31:0] rq;
        logic [31:0] npc;
        logic        redir;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 0;

    // Reference state: what the previous instruction left behind at the edge.
    logic [31:0] m_result, m_target;
    logic        m_zero, m_less;
    logic [2:0]  m_code;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b,
                                             logic [31:0] pc);
        int signed sa, sb2;
        sa  = a;
        sb2 = b;
        case (op)
            1:  return b;
            2:  return pc + b;
            3:  return a + b;
            4, 5, 6, 7, 8, 9: return a - b;
            10: return (sa < sb2) ? 32'd1 : 32'd0;
            11: return (a < b) ? 32'd1 : 32'd0;
            12: return a ^ b;
            13: return a | b;
            14: return a & b;
`ifdef EX_SHIFT_EN
            15: return a << b[4:0];
            16: return a >> b[4:0];
            17: return sa >>> b[4:0];
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_less(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        int signed sa, sb2;
        sa  = a;
        sb2 = b;
        if (op == 8 || op == 9 || op == 11) return a < b;
        return sa < sb2;
    endfunction

    function automatic logic ref_taken(logic [2:0] code, logic z, logic l);
        case (code)
            1: return z;
            2: return !z;
            3: return l;
            4: return !l;
            5, 6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_result = 0; m_target = 0; m_zero = 0; m_less = 0; m_code = 0;
    endtask

    // Apply one instruction at the falling edge and queue what the DUT should
    // show for it (comb outputs) and for the instruction before it (registered).
    task automatic drive(logic [31:0] pc, logic [31:0] a, logic [31:0] r2, logic [31:0] imm,
                         logic src, logic [4:0] op, logic [2:0] code, logic [31:0] pc4);
        exp_t e;
        logic [31:0] b;
        logic        tk;
        @(negedge clk);
        pc_i = pc; rd1_i = a; rd2_i = r2; imm_i = imm; alu_src_i = src;
        alu_op_i = op; pc_src_i = code; pc_plus4_i = pc4;
        b       = src ? imm : r2;
        e.c     = ref_alu(op, a, b, pc);
        e.z     = (e.c == 0);
        e.l     = ref_less(op, a, b);
        tk      = ref_taken(m_code, m_zero, m_less);
        e.rq    = m_result;
        e.redir = tk;
        if (!tk)            e.npc = pc4;
        else if (m_code == 6) e.npc = m_result & ~32'd1;
        else                e.npc = m_target;
        m_result = e.c;
        m_zero   = e.z;
        m_less   = e.l;
        m_target = pc + imm;
        m_code   = tk ? 3'd0 : code;
        if (mon_en) sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("alu_c",    alu_c_o,    e.c);
                    check("zero",     {31'd0, zero_o},     {31'd0, e.z});
                    check("less",     {31'd0, less_o},     {31'd0, e.l});
                    check("result_q", result_q_o, e.rq);
                    check("next_pc",  next_pc_o,  e.npc);
                    check("redirect", {31'd0, redirect_o}, {31'd0, e.redir});
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] a, r2, imm, pc;
        logic [4:0]  op;
        logic [2:0]  code;
        rst = 1'b1;
        pc_i = 0; rd1_i = 0; rd2_i = 0; imm_i = 0; alu_src_i = 0;
        alu_op_i = 0; pc_src_i = 0; pc_plus4_i = 32'h44;
        #2;
        check("rst_result_q", result_q_o, 32'd0);
        check("rst_redirect", {31'd0, redirect_o}, 32'd0);
        check("rst_next_pc",  next_pc_o, 32'h44);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #4;
        mon_en = 1;

        // operand mux, add/sub
        drive(32'h0, 5, 3, 32'hFFFF_FFFF, 1, 3, 0, 32'h4);
        #3 check("add_imm", alu_c_o, 32'd4);
        drive(32'h0, 5, 3, 32'hFFFF_FFFF, 0, 4, 0, 32'h8);
        #3 check("sub_reg", alu_c_o, 32'd2);
        check("sub_zero", {31'd0, zero_o}, 32'd0);
        // signed vs unsigned set-less-than
        drive(32'h0, 32'hFFFF_FFFF, 1, 0, 0, 10, 0, 32'hC);
        #3 check("slt", alu_c_o, 32'd1);
        check("slt_less", {31'd0, less_o}, 32'd1);
        drive(32'h0, 32'hFFFF_FFFF, 1, 0, 0, 11, 0, 32'h10);
        #3 check("sltu", alu_c_o, 32'd0);
        check("sltu_less", {31'd0, less_o}, 32'd0);
        // beq taken, followed by a jal that must be squashed
        drive(32'h100, 7, 7, 32'h20, 0, 4, 1, 32'h104);
        drive(32'h104, 1, 2, 32'h40, 0, 3, 5, 32'h108);
        #3 check("beq_npc", next_pc_o, 32'h120);
        check("beq_redirect", {31'd0, redirect_o}, 32'd1);
        drive(32'h120, 0, 0, 0, 0, 0, 0, 32'h124);
        #3 check("squash_npc", next_pc_o, 32'h124);
        check("squash_redirect", {31'd0, redirect_o}, 32'd0);
        // jalr clears bit 0
        drive(32'h200, 32'h203, 0, 0, 1, 3, 6, 32'h204);
        drive(32'h204, 0, 0, 0, 0, 0, 0, 32'h208);
        #3 check("jalr_npc", next_pc_o, 32'h202);
        check("jalr_redirect", {31'd0, redirect_o}, 32'd1);
        // arithmetic shift right
        drive(32'h300, 32'h8000_0000, 4, 0, 0, 17, 0, 32'h304);
`ifdef EX_SHIFT_EN
        #3 check("sra", alu_c_o, 32'hF800_0000);
`else
        #3 check("sra_off", alu_c_o, 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            a   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
            r2  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom);
            imm = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            op  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
            code = 3'($urandom_range(0, 7));
            drive(pc, a, r2, imm, 1'($urandom_range(0, 1)), op, code, pc + 4);
        end

        // async reset while a redirect is pending
        #4;
        mon_en = 0;
        sb.delete();
        drive(32'h100, 7, 7, 32'h20, 0, 4, 1, 32'h104);
        drive(32'h104, 0, 0, 0, 0, 0, 0, 32'h108);
        #2 check("pre_rst_redirect", {31'd0, redirect_o}, 32'd1);
        check("pre_rst_result_q", result_q_o, 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_redirect", {31'd0, redirect_o}, 32'd0);
        check("mid_rst_result_q", result_q_o, 32'd0);
        check("mid_rst_next_pc", next_pc_o, 32'h108);
        // second instruction drove a zero result, so make that edge visible first
        rst = 1'b0;
        drive(32'h0, 32'h10, 32'h3, 0, 0, 3, 0, 32'h8);
        @(posedge clk);
        #1 check("post_rst_result_q", result_q_o, 32'h13);
        rst = 1'b1;
        #1 check("async_clear_result_q", result_q_o, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
